// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush, EX-busy freeze and a saturating stall-cycle counter.
module id_ex_hazard_reg #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [1:0]       id_WB,
  input  logic [1:0]       id_M,
  input  logic [3:0]       id_EX,
  input  logic             flush,
  input  logic             ex_busy,
  output logic             ex_valid,
  output logic [RW-1:0]    ex_rs,
  output logic [RW-1:0]    ex_rt,
  output logic [RW-1:0]    ex_rd,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [1:0]       ex_WB,
  output logic [1:0]       ex_M,
  output logic [3:0]       ex_EX,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, HOLD, LU_BUB} state_t;

  state_t state;
  logic   lu;
  logic   stall;
  logic   bubble;

  // A load in EX whose destination feeds the decode instruction; $0 is exempt.
  // Masked in LU_BUB so one load-use pair can never produce two bubbles.
  assign lu = (state != LU_BUB) & ex_valid & ex_M[1] & (ex_rt != '0) & id_valid &
              ((ex_rt == id_rs) | (ex_rt == id_rt));

  assign stall      = ~rst & ~flush & (ex_busy | lu);
  assign bubble     = flush | (~ex_busy & lu);
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_WB      <= '0;
      ex_M       <= '0;
      ex_EX      <= '0;
    end else if (!ex_busy) begin
      ex_valid   <= id_valid;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_WB      <= id_WB;
      ex_M       <= id_M;
      ex_EX      <= id_EX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= ex_busy ? HOLD : (lu ? LU_BUB : RUN);
        HOLD:    state <= ex_busy ? HOLD : (lu ? LU_BUB : RUN);
        LU_BUB:  state <= ex_busy ? HOLD : RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed plus randomized bench for id_ex_hazard_reg, checked against a
// cycle-level behavioural model of the pipeline register and stall rules.
module tb_id_ex_hazard_reg;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [1:0]    id_WB, id_M;
  logic [3:0]    id_EX;
  logic          flush, ex_busy;

  logic          ex_valid, pc_write, ifid_write;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [1:0]    ex_WB, ex_M;
  logic [3:0]    ex_EX;
  logic [15:0]   stall_cnt;

  logic          s_valid, s_pc, s_ifid;
  logic [RW-1:0] s_rs, s_rt, s_rd;
  logic [DW-1:0] s_rsd, s_rtd, s_imm;
  logic [1:0]    s_wb, s_m;
  logic [3:0]    s_ex;
  logic [1:0]    s_cnt;

  int compared = 0;
  int mismatched = 0;

  // Reference model: the ID/EX contents as one record plus two stall totals.
  typedef struct {
    logic          valid;
    logic [RW-1:0] rs, rt, rd;
    logic [DW-1:0] rsd, rtd, imm;
    logic [1:0]    wb, m;
    logic [3:0]    ex;
  } slot_t;

  slot_t slot;
  int    m_cnt;
  int    m_cnt2;

  always #5 clk = ~clk;

  id_ex_hazard_reg #(.DW(DW), .RW(RW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_WB(id_WB), .id_M(id_M), .id_EX(id_EX),
    .flush(flush), .ex_busy(ex_busy), .ex_valid(ex_valid), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_WB(ex_WB), .ex_M(ex_M),
    .ex_EX(ex_EX), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_cnt(stall_cnt)
  );

  id_ex_hazard_reg #(.DW(DW), .RW(RW), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_WB(id_WB), .id_M(id_M), .id_EX(id_EX),
    .flush(flush), .ex_busy(ex_busy), .ex_valid(s_valid), .ex_rs(s_rs),
    .ex_rt(s_rt), .ex_rd(s_rd), .ex_rs_data(s_rsd),
    .ex_rt_data(s_rtd), .ex_imm(s_imm), .ex_WB(s_wb), .ex_M(s_m),
    .ex_EX(s_ex), .pc_write(s_pc), .ifid_write(s_ifid),
    .stall_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_stall();
    logic hazard;
    hazard = slot.valid && slot.m[1] && (slot.rt != 0) && id_valid &&
             (slot.rt == id_rs || slot.rt == id_rt);
    return !rst && !flush && (ex_busy || hazard);
  endfunction

  // Advance the model by one clock: flush > busy > load-use > capture.
  task automatic model_clock(input logic stalled);
    slot_t empty;
    empty = '{valid: 1'b0, rs: '0, rt: '0, rd: '0, rsd: '0, rtd: '0, imm: '0,
              wb: '0, m: '0, ex: '0};
    if (rst) begin
      slot   = empty;
      m_cnt  = 0;
      m_cnt2 = 0;
    end else begin
      if (flush) slot = empty;
      else if (ex_busy) slot = slot;
      else if (stalled) slot = empty;
      else slot = '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
                    rsd: id_rs_data, rtd: id_rt_data, imm: id_imm,
                    wb: id_WB, m: id_M, ex: id_EX};
      if (stalled) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  task automatic check_regs();
    chk("ex_valid", 64'(ex_valid), 64'(slot.valid));
    chk("ex_rs", 64'(ex_rs), 64'(slot.rs));
    chk("ex_rt", 64'(ex_rt), 64'(slot.rt));
    chk("ex_rd", 64'(ex_rd), 64'(slot.rd));
    chk("ex_rs_data", 64'(ex_rs_data), 64'(slot.rsd));
    chk("ex_rt_data", 64'(ex_rt_data), 64'(slot.rtd));
    chk("ex_imm", 64'(ex_imm), 64'(slot.imm));
    chk("ex_WB", 64'(ex_WB), 64'(slot.wb));
    chk("ex_M", 64'(ex_M), 64'(slot.m));
    chk("ex_EX", 64'(ex_EX), 64'(slot.ex));
    chk("small_ex_valid", 64'(s_valid), 64'(slot.valid));
    chk("small_ex_rt", 64'(s_rt), 64'(slot.rt));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk("stall_cnt_w2", 64'(s_cnt), 64'(m_cnt2));
  endtask

  // One cycle: settle, check the combinational stall outputs, clock, check state.
  task automatic step();
    logic stalled;
    #1;
    stalled = model_stall();
    chk("pc_write", 64'(pc_write), 64'(!stalled));
    chk("ifid_write", 64'(ifid_write), 64'(!stalled));
    chk("small_pc_write", 64'(s_pc), 64'(!stalled));
    @(posedge clk);
    model_clock(stalled);
    #1;
    check_regs();
  endtask

  task automatic set_instr(input logic v, input int rs, input int rt, input int rd,
                           input logic [1:0] wb, input logic [1:0] m);
    id_valid   = v;
    id_rs      = RW'(rs);
    id_rt      = RW'(rt);
    id_rd      = RW'(rd);
    id_rs_data = $urandom;
    id_rt_data = $urandom;
    id_imm     = $urandom;
    id_WB      = wb;
    id_M       = m;
    id_EX      = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_busy = 1'b0;
    set_instr(1'b1, 1, 2, 3, 2'b11, 2'b10);

    // Reset held two cycles
    step();
    step();
    chk("t1_stall_cnt_zero", 64'(stall_cnt), 64'd0);
    chk("t1_pc_write", 64'(pc_write), 64'd1);
    rst = 1'b0;

    // Passthrough
    set_instr(1'b1, 3, 4, 5, 2'b10, 2'b00);
    id_rs_data = 32'h11;
    step();
    chk("t2_ex_rs", 64'(ex_rs), 64'd3);
    chk("t2_ex_rs_data", 64'(ex_rs_data), 64'h11);
    chk("t2_ex_WB", 64'(ex_WB), 64'b10);

    // Load-use on r8: one bubble, then the dependent instruction issues
    set_instr(1'b1, 1, 8, 8, 2'b11, 2'b10);
    step();
    set_instr(1'b1, 8, 2, 9, 2'b10, 2'b00);
    #1;
    chk("t3_pc_write_low", 64'(pc_write), 64'd0);
    step();
    chk("t3_bubble_wb", 64'(ex_WB), 64'd0);
    chk("t3_stall_cnt", 64'(stall_cnt), 64'd1);
    step();
    chk("t3_issued_rs", 64'(ex_rs), 64'd8);

    // Load to $0 followed by a $0 reader: no stall
    set_instr(1'b1, 1, 0, 0, 2'b11, 2'b10);
    step();
    set_instr(1'b1, 0, 0, 4, 2'b10, 2'b00);
    step();
    chk("t4_no_stall_cnt", 64'(stall_cnt), 64'd1);

    // Flush coinciding with a load-use hazard
    set_instr(1'b1, 1, 8, 8, 2'b11, 2'b10);
    step();
    set_instr(1'b1, 8, 2, 9, 2'b10, 2'b00);
    flush = 1'b1;
    #1;
    chk("t5_pc_write_high", 64'(pc_write), 64'd1);
    step();
    flush = 1'b0;
    chk("t5_bubble_valid", 64'(ex_valid), 64'd0);
    chk("t5_stall_cnt", 64'(stall_cnt), 64'd1);

    // EX busy for three cycles freezes ID/EX and saturates the 2-bit counter
    set_instr(1'b1, 5, 6, 7, 2'b10, 2'b01);
    step();
    ex_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, 10 + i, 11, 12, 2'b11, 2'b00);
      step();
      chk("t6_frozen_rs", 64'(ex_rs), 64'd5);
    end
    ex_busy = 1'b0;
    chk("t6_stall_cnt", 64'(stall_cnt), 64'd4);
    chk("t6_small_sat", 64'(s_cnt), 64'd3);

    // Randomized traffic with a narrow register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      set_instr(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      flush   = ($urandom_range(0, 9) == 0);
      ex_busy = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
